// File: rtl/maxpool_engine.sv
// 2x2 max-pooling engine: reads each 2x2 window from layer-0 memory, writes the max to layer 1.
// Optional MAXPOOL_CEIL_EN rounds the pooled value up to the next integer.
module maxpool_engine #(
  parameter int IMG_LOG2 = 6,
  parameter int DATA_W   = 20
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  crd,
  output logic [2*IMG_LOG2-1:0] caddr_rd,
  input  logic [DATA_W-1:0]     cdata_rd,
  output logic                  cwr,
  output logic [2*IMG_LOG2-1:0] caddr_wr,
  output logic [DATA_W-1:0]     cdata_wr,
  output logic [2:0]            csel
);

  localparam int AW     = 2 * IMG_LOG2;
  localparam int OW     = IMG_LOG2 - 1;
  localparam int FRAC_W = 16;
  localparam int INT_W  = DATA_W - FRAC_W;

  typedef enum logic [2:0] {IDLE, RD, LAST, WR, FIN} state_t;

  state_t                     state, state_nxt;
  logic [1:0]                 rd_idx;
  logic [OW-1:0]              row, col;
  logic signed [DATA_W-1:0]   max_q;
  logic [DATA_W-1:0]          pooled;
  logic                       last_win;

  assign last_win = (&row) & (&col);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      rd_idx <= '0;
      row    <= '0;
      col    <= '0;
      max_q  <= '0;
    end else begin
      state <= state_nxt;
      if (state == RD) begin
        rd_idx <= rd_idx + 2'd1;
        // First sample of a window loads unconditionally; ties keep the earlier sample.
        if (rd_idx == 2'd0 || $signed(cdata_rd) > max_q) max_q <= $signed(cdata_rd);
      end
      if (state == WR) begin
        col <= col + 1'b1;
        if (&col) row <= row + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RD;
      RD:      if (rd_idx == 2'd3) state_nxt = LAST;
      LAST:    state_nxt = WR;
      WR:      state_nxt = last_win ? FIN : RD;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef MAXPOOL_CEIL_EN
  always_comb begin
    pooled = max_q;
    if (|max_q[FRAC_W-1:0])
      pooled = {max_q[DATA_W-1:FRAC_W] + INT_W'(1), {FRAC_W{1'b0}}};
  end
`else
  assign pooled = max_q;
`endif

  always_comb begin
    crd      = 1'b0;
    cwr      = 1'b0;
    csel     = 3'b000;
    caddr_rd = '0;
    caddr_wr = '0;
    cdata_wr = '0;
    busy     = (state != IDLE);
    done     = (state == FIN);
    case (state)
      RD: begin
        crd      = 1'b1;
        csel     = 3'b001;
        // Row 2r+idx[1], column 2c+idx[0] of the full-resolution image.
        caddr_rd = {row, rd_idx[1], col, rd_idx[0]};
      end
      WR: begin
        cwr      = 1'b1;
        csel     = 3'b011;
        caddr_wr = {{(AW-2*OW){1'b0}}, row, col};
        cdata_wr = pooled;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/maxpool_engine.md
MAXPOOL_ENGINE -- requirements
Module: maxpool_engine

Interface
REQ-001 Parameter: IMG_LOG2, default 6, log2 of the square input image side (64x64 input produces a 32x32 output).
REQ-002 Parameter: DATA_W, default 20, pixel width; signed 4.16 fixed point.
REQ-003 The ports SHALL be exactly:
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to pool one layer.
- busy  out  1  high while pooling is in progress.
- done  out  1  one-cycle pulse on completion.
- crd  out  1  layer-0 memory read strobe.
- caddr_rd  out  12  layer-0 read address, row*64+col.
- cdata_rd  in  20  layer-0 read data, valid at the rising edge following the crd cycle.
- cwr  out  1  layer-1 memory write strobe.
- caddr_wr  out  12  layer-1 write address, row*32+col.
- cdata_wr  out  20  layer-1 write data.
- csel  out  3  memory select: 3'b001 layer 0, 3'b011 layer 1, 3'b000 idle.

Function
REQ-004 States SHALL be IDLE, RD, LAST, WR and FIN.
- IDLE: start=1 moves to RD.
- RD: 4 cycles, then LAST.
- LAST: 1 cycle, then WR.
- WR: 1 cycle; moves to RD if windows remain, else FIN.
- FIN: 1 cycle, then IDLE.
REQ-005 Windows SHALL be processed in raster order, output (r,c) from (0,0) to (31,31), 1024 windows in total.
REQ-006 In RD, the 4 reads SHALL be issued in this order: (2r,2c), (2r,2c+1), (2r+1,2c), (2r+1,2c+1).
- crd=1 and csel=3'b001 for all 4 cycles.
- caddr_rd holds the address for the current cycle.
REQ-007 Each cdata_rd sample SHALL be captured at the edge after its issue cycle; the 4th sample is captured in LAST.
REQ-008 The maximum SHALL be computed as a signed DATA_W comparison; on a tie the earlier sample is kept.
REQ-009 In WR, outputs SHALL be:
- cwr=1, csel=3'b011, caddr_wr=r*32+c.
- cdata_wr = pooled value (REQ-014).
- crd=0.
REQ-010 crd and cwr SHALL never be high in the same cycle; csel=3'b000 whenever both are low.
REQ-011 Timing from start:
- busy rises on the edge that samples start=1, and stays high through FIN.
- done=1 only in FIN; busy falls as done falls.
- Throughput is 6 cycles per window; total of 6144 cycles from start to done.
REQ-012 start SHALL be ignored while busy=1; start held high in IDLE after FIN SHALL begin a new run.
REQ-013 Counters SHALL wrap from (31,31) to (0,0) at the end of a run, so no address ever exceeds 4095 (read) or 1023 (write).

Reset
REQ-015 reset=0 SHALL immediately return the FSM to IDLE and clear all counters and the max register, regardless of the current state.
REQ-016 During and after reset, outputs SHALL be: busy=0, done=0, crd=0, cwr=0, csel=3'b000, caddr_rd=0, caddr_wr=0, cdata_wr=0.
REQ-017 A reset during a run SHALL abandon it; no further write occurs until a new start.

Configuration
REQ-014 Macro MAXPOOL_CEIL_EN SHALL control rounding of the pooled value:
- Defined: if max[15:0]!=0, cdata_wr = {max[19:16]+1, 16'h0000}, with the integer add taken modulo 16; otherwise cdata_wr = max.
- Undefined: cdata_wr = max, unmodified.
- No other behaviour or timing SHALL differ between the two builds.

Verification
REQ-018 Window (0,0) with layer-0 values 0x10000, 0x28000, 0x18000, 0x00000 -> write at L1 address 0: 0x30000 with CEIL_EN, 0x28000 without.
REQ-019 Window holding four equal values 0x20000 -> 0x20000 in both builds.
REQ-020 Window holding 0x7C000, 0x00001, 0x00000, 0x00000 -> with CEIL_EN, 0x80000 (wrap).
REQ-021 Full run: start pulse -> exactly 1024 writes, addresses 0..1023 in order, done pulse 6144 cycles after start, and crd/cwr never high together.
REQ-022 Assert reset=0 at window 500 mid-RD -> outputs clear within the same cycle; the next start restarts at L1 address 0.
REQ-023 Pulse start while busy at cycle 100 -> no effect on sequence, address order or done timing.
